// File: rtl/cpu_run_pkg.sv
// rtl/cpu_run_pkg.sv - shared state type, defaults and width helper for the core run controller
package cpu_run_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RESET,
      ST_RUN,
      ST_PAUSE,
      ST_STEP_WAIT,
      ST_STEP,
      ST_DONE
   } run_state_t;

   localparam int DEF_PC_W       = 32;
   localparam int DEF_CYCLE_W    = 32;
   localparam int DEF_MAX_CYCLES = 100;
   localparam int DEF_RST_CYCLES = 2;
   localparam int DEF_NUM_BREAK  = 2;

   // Index width for n entries, never narrower than one bit.
   function automatic int bp_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/bp_matcher.sv
// rtl/bp_matcher.sv - PC breakpoint comparator array with lowest-index priority
module bp_matcher
   import cpu_run_pkg::*;
#(
   parameter int PC_W      = DEF_PC_W,
   parameter int NUM_BREAK = DEF_NUM_BREAK,
   parameter int IDX_W     = bp_idx_w(NUM_BREAK)
) (
   input  logic [PC_W-1:0]           pc,
   input  logic [NUM_BREAK*PC_W-1:0] bp_addr,
   input  logic [NUM_BREAK-1:0]      bp_en,
   output logic                      match,
   output logic [IDX_W-1:0]          idx
);

   // Scan from the top down so the lowest matching entry is the last writer.
   always_comb begin
      match = 1'b0;
      idx   = '0;
      for (int i = NUM_BREAK - 1; i >= 0; i--) begin
         if (bp_en[i] && (bp_addr[i*PC_W +: PC_W] == pc)) begin
            match = 1'b1;
            idx   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run controller: core reset pulse, enable gating, halt/breakpoint/budget stop, single step
module cpu_run_ctrl
   import cpu_run_pkg::*;
#(
   parameter int PC_W       = DEF_PC_W,
   parameter int CYCLE_W    = DEF_CYCLE_W,
   parameter int MAX_CYCLES = DEF_MAX_CYCLES,
   parameter int RST_CYCLES = DEF_RST_CYCLES,
   parameter int NUM_BREAK  = DEF_NUM_BREAK
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           start,
   input  logic                           step_mode,
   input  logic                           step_req,
   input  logic                           halt_in,
   input  logic [PC_W-1:0]                pc_in,
   input  logic [NUM_BREAK*PC_W-1:0]      bp_addr,
   input  logic [NUM_BREAK-1:0]           bp_en,
   output logic                           core_rst,
   output logic                           core_en,
   output logic                           busy,
   output logic                           done,
   output logic                           timeout,
   output logic                           bp_hit,
   output logic [bp_idx_w(NUM_BREAK)-1:0] bp_idx,
   output logic [CYCLE_W-1:0]             cycle_count
);

   localparam int IDX_W = bp_idx_w(NUM_BREAK);
   localparam int RC_W  = bp_idx_w(RST_CYCLES);
   localparam logic [RC_W-1:0]    RST_LAST = RC_W'(RST_CYCLES - 1);
   localparam logic [CYCLE_W-1:0] LAST_CYC = CYCLE_W'(MAX_CYCLES - 1);

   run_state_t       state;
   run_state_t       state_nxt;
   logic [RC_W-1:0]  rst_cnt;
   logic             skip_bp;
   logic             match;
   logic [IDX_W-1:0] match_idx;
   logic             bp_fire;
   logic             at_budget;
   logic             counting;
   logic             new_run;

   bp_matcher #(
      .PC_W      (PC_W),
      .NUM_BREAK (NUM_BREAK),
      .IDX_W     (IDX_W)
   ) u_bp_matcher (
      .pc      (pc_in),
      .bp_addr (bp_addr),
      .bp_en   (bp_en),
      .match   (match),
      .idx     (match_idx)
   );

   // ">=" keeps the budget honest even if a breakpoint paused exactly on the last cycle.
   assign at_budget = (cycle_count >= LAST_CYC);
   assign bp_fire   = match && !skip_bp;
   assign counting  = (state == ST_RUN) || (state == ST_STEP);
   assign new_run   = start && ((state == ST_IDLE) || (state == ST_DONE));

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:      if (start) state_nxt = ST_RESET;
         ST_RESET:     if (rst_cnt == RST_LAST) state_nxt = step_mode ? ST_STEP_WAIT : ST_RUN;
         ST_RUN: begin
            if (halt_in)        state_nxt = ST_DONE;
            else if (bp_fire)   state_nxt = ST_PAUSE;
            else if (at_budget) state_nxt = ST_DONE;
         end
         ST_PAUSE:     if (start) state_nxt = ST_RUN;
         ST_STEP_WAIT: if (step_req) state_nxt = ST_STEP;
         ST_STEP:      state_nxt = (halt_in || at_budget) ? ST_DONE : ST_STEP_WAIT;
         ST_DONE:      if (start) state_nxt = ST_RESET;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         rst_cnt     <= '0;
         skip_bp     <= 1'b0;
         core_rst    <= 1'b1;
         core_en     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         bp_hit      <= 1'b0;
         bp_idx      <= '0;
         cycle_count <= '0;
      end else begin
         state    <= state_nxt;
         core_rst <= (state_nxt == ST_IDLE) || (state_nxt == ST_RESET);
         core_en  <= (state_nxt == ST_RUN) || (state_nxt == ST_STEP);
         busy     <= (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
         rst_cnt  <= ((state == ST_RESET) && (state_nxt == ST_RESET)) ? rst_cnt + RC_W'(1) : '0;

         if (new_run) begin
            done        <= 1'b0;
            timeout     <= 1'b0;
            bp_hit      <= 1'b0;
            cycle_count <= '0;
         end

         if (counting) begin
            if (cycle_count != '1) cycle_count <= cycle_count + CYCLE_W'(1);
            if (state_nxt == ST_DONE) begin
               done    <= 1'b1;
               timeout <= !halt_in;
            end
         end

         if (state == ST_RUN) begin
            skip_bp <= 1'b0;
            if (state_nxt == ST_PAUSE) begin
               bp_hit <= 1'b1;
               bp_idx <= match_idx;
            end
         end

         // Resume arms skip-once so the core steps off the PC it stopped on.
         if ((state == ST_PAUSE) && start) begin
            bp_hit  <= 1'b0;
            skip_bp <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb/tb_cpu_run_ctrl.sv - self-checking bench for cpu_run_ctrl against a behavioural run model
module tb_cpu_run_ctrl;

   localparam int PC_W = 32;
   localparam int NB   = 2;
   localparam int MAXC = 100;
   localparam int RSTC = 2;

   localparam int P_OFF = 0, P_HOLD = 1, P_GO = 2, P_BRK = 3, P_WAIT = 4, P_ONE = 5, P_END = 6;

   logic              clk = 1'b0;
   logic              rst;
   logic              start, step_mode, step_req, halt_in;
   logic [PC_W-1:0]   pc_in;
   logic [NB*PC_W-1:0] bp_addr;
   logic [NB-1:0]     bp_en;
   logic              core_rst, core_en, busy, done, timeout, bp_hit;
   logic [0:0]        bp_idx;
   logic [31:0]       cycle_count;

   int n_vec = 0;
   int n_bad = 0;
   bit chk_on = 0;

   int ph, hold_left, cnt, m_idx;
   bit skip, m_done, m_to, m_bp;

   cpu_run_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step_req(step_req),
      .halt_in(halt_in), .pc_in(pc_in), .bp_addr(bp_addr), .bp_en(bp_en),
      .core_rst(core_rst), .core_en(core_en), .busy(busy), .done(done), .timeout(timeout),
      .bp_hit(bp_hit), .bp_idx(bp_idx), .cycle_count(cycle_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   function automatic int bp_first();
      for (int i = 0; i < NB; i++)
         if (bp_en[i] && bp_addr[i*PC_W +: PC_W] == pc_in) return i;
      return -1;
   endfunction

   task automatic model_reset();
      ph = P_OFF; hold_left = 0; cnt = 0; m_idx = 0;
      skip = 0; m_done = 0; m_to = 0; m_bp = 0;
   endtask

   task automatic finish_run(input bit by_budget);
      ph = P_END; m_done = 1; m_to = by_budget;
   endtask

   task automatic model_step();
      int hit;
      hit = bp_first();
      if (rst) model_reset();
      else case (ph)
         P_OFF, P_END: if (start) begin
            ph = P_HOLD; hold_left = RSTC; cnt = 0; m_done = 0; m_to = 0; m_bp = 0;
         end
         P_HOLD: begin
            hold_left--;
            if (hold_left == 0) ph = step_mode ? P_WAIT : P_GO;
         end
         P_GO: begin
            cnt++;
            if (halt_in) finish_run(0);
            else if (hit >= 0 && !skip) begin ph = P_BRK; m_bp = 1; m_idx = hit; end
            else if (cnt >= MAXC) finish_run(1);
            skip = 0;
         end
         P_BRK: if (start) begin ph = P_GO; m_bp = 0; skip = 1; end
         P_WAIT: if (step_req) ph = P_ONE;
         P_ONE: begin
            cnt++;
            if (halt_in) finish_run(0);
            else if (cnt >= MAXC) finish_run(1);
            else ph = P_WAIT;
         end
         default: model_reset();
      endcase
   endtask

   always @(negedge clk) begin
      if (chk_on) begin
         chk("core_rst", core_rst, (ph == P_OFF || ph == P_HOLD));
         chk("core_en", core_en, (ph == P_GO || ph == P_ONE));
         chk("busy", busy, (ph != P_OFF && ph != P_END));
         chk("done", done, m_done);
         chk("timeout", timeout, m_to);
         chk("bp_hit", bp_hit, m_bp);
         chk("bp_idx", bp_idx, m_idx);
         chk("cycle_count", cycle_count, cnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      #2;
   endtask

   task automatic run_to_done(input int budget);
      for (int k = 0; k < budget && !done; k++) tick();
      chk("run_to_done", done, 1);
   endtask

   task automatic wait_en_count(input int target, output int seen);
      seen = 0;
      for (int k = 0; k < 300; k++) begin
         if (core_en) seen++;
         if (seen == target) break;
         tick();
      end
   endtask

   task automatic kick();
      start = 1; tick(); start = 0;
   endtask

   initial begin
      int rh, eh, rises, seen;
      bit prev;
      rst = 0; start = 0; step_mode = 0; step_req = 0; halt_in = 0;
      pc_in = 32'h100; bp_addr = '0; bp_en = '0;
      model_reset();
      #1 rst = 1;
      #2;
      chk("reset_core_rst", core_rst, 1);
      chk("reset_core_en", core_en, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_count", cycle_count, 0);
      tick(); tick();
      rst = 0; chk_on = 1;
      tick();

      // Budget expiry
      kick();
      rh = 0; eh = 0; rises = 0; prev = 0;
      for (int k = 0; k < 400 && !done; k++) begin
         if (core_rst) rh++;
         if (core_en) begin eh++; if (!prev) rises++; end
         prev = core_en;
         pc_in = 32'h100 + k;
         tick();
      end
      chk("to_rst_cycles", rh, 2);
      chk("to_en_cycles", eh, 100);
      chk("to_en_bursts", rises, 1);
      chk("to_done", done, 1);
      chk("to_timeout", timeout, 1);
      chk("to_count", cycle_count, 100);
      chk("to_core_rst", core_rst, 0);

      // Halt on the 37th enabled cycle
      kick();
      wait_en_count(37, seen);
      halt_in = 1; tick(); halt_in = 0;
      chk("halt_en", core_en, 0);
      chk("halt_done", done, 1);
      chk("halt_timeout", timeout, 0);
      chk("halt_count", cycle_count, 37);

      // Breakpoint, pause and skip-once resume
      bp_addr = {32'h0, 32'h10}; bp_en = 2'b01; pc_in = 32'h100;
      kick();
      wait_en_count(5, seen);
      pc_in = 32'h10; tick();
      chk("bp_hit", bp_hit, 1);
      chk("bp_idx", bp_idx, 0);
      chk("bp_count", cycle_count, 5);
      chk("bp_en_off", core_en, 0);
      tick();
      chk("bp_pause_held", bp_hit, 1);
      kick();
      chk("bp_resume_en", core_en, 1);
      chk("bp_resume_clear", bp_hit, 0);
      tick();
      chk("bp_no_rehit", core_en, 1);
      chk("bp_resume_count", cycle_count, 6);
      pc_in = 32'h100;
      run_to_done(300);
      chk("bp_run_count", cycle_count, 100);

      // Halt beats breakpoints; lowest index wins; upper entry alone
      bp_addr = {32'h20, 32'h20}; bp_en = 2'b11;
      kick();
      wait_en_count(1, seen);
      pc_in = 32'h20; halt_in = 1; tick(); halt_in = 0; pc_in = 32'h100;
      chk("prio_done", done, 1);
      chk("prio_bp_hit", bp_hit, 0);
      kick();
      wait_en_count(1, seen);
      pc_in = 32'h20; tick(); pc_in = 32'h100;
      chk("prio_bp_hit2", bp_hit, 1);
      chk("prio_idx0", bp_idx, 0);
      bp_en = 2'b10;
      kick(); tick();
      pc_in = 32'h20; tick(); pc_in = 32'h100;
      chk("prio_idx1", bp_idx, 1);
      chk("prio_bp_hit3", bp_hit, 1);
      bp_en = 2'b00;
      kick();
      run_to_done(300);

      // Single step: three requests four cycles apart
      step_mode = 1;
      kick(); tick(); tick(); tick();
      step_mode = 0;
      eh = 0;
      for (int p = 0; p < 3; p++) begin
         step_req = 1; tick(); step_req = 0;
         if (core_en) eh++;
         for (int q = 0; q < 3; q++) begin tick(); if (core_en) eh++; end
      end
      chk("step_pulses", eh, 3);
      chk("step_count", cycle_count, 3);
      chk("step_busy", busy, 1);
      chk("step_done", done, 0);

      // Asynchronous reset from step wait, then mid-run
      #1 rst = 1; model_reset();
      #1;
      chk("arst_step_count", cycle_count, 0);
      tick(); rst = 0;
      kick();
      for (int k = 0; k < 200 && cycle_count != 50; k++) tick();
      chk("arst_reached_50", cycle_count, 50);
      #1 rst = 1; model_reset();
      #1;
      chk("arst_core_rst", core_rst, 1);
      chk("arst_core_en", core_en, 0);
      chk("arst_count", cycle_count, 0);
      chk("arst_busy", busy, 0);
      tick(); rst = 0;
      kick();
      run_to_done(300);
      chk("arst_rerun_count", cycle_count, 100);
      chk("arst_rerun_timeout", timeout, 1);

      // Randomised traffic against the model
      for (int k = 0; k < 3000; k++) begin
         if (k % 200 == 0) begin
            bp_addr = {32'($urandom_range(0, 7)), 32'($urandom_range(0, 7))};
            bp_en   = 2'($urandom_range(0, 3));
         end
         start     = ($urandom_range(0, 9) == 0);
         step_req  = ($urandom_range(0, 3) == 0);
         halt_in   = ($urandom_range(0, 59) == 0);
         step_mode = 1'($urandom_range(0, 1));
         pc_in     = 32'($urandom_range(0, 7));
         tick();
      end
      start = 0; step_req = 0; halt_in = 0;
      tick();
      chk_on = 0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
